// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths, defaults and FSM encoding for the DCT frame sequencer
// Contents: default M/E/DCT_POINT/TIMEOUT, sequencer state enum, sample and index width helpers.
package dct_pkg;

    localparam int M_DEF         = 23;
    localparam int E_DEF         = 8;
    localparam int DCT_POINT_DEF = 16;
    localparam int TIMEOUT_DEF   = 64;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_GAP   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } seq_state_t;

    // IEEE-754 style sample: sign + exponent + mantissa
    function automatic int sample_width(input int m, input int e);
        return m + e + 1;
    endfunction

    // Lane index width; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dct_frame_sequencer_if.sv
// rtl/dct_frame_sequencer_if.sv - valid/ready sample stream between sequencer and neighbours
// Signals: data (W), valid, ready. master drives data/valid, slave drives ready.
interface dct_frame_sequencer_if #(
    parameter int W = dct_pkg::sample_width(dct_pkg::M_DEF, dct_pkg::E_DEF)
) ();

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/dct_coef_serializer.sv
// rtl/dct_coef_serializer.sv - captures the parallel coefficient frame and streams it lane by lane
// Ports: clk, clr (sync active-high), cap (load coef_in this edge), coef_in (W*DCT_POINT),
//        m (stream master: coefficient out), done (last coefficient handed off this cycle).
module dct_coef_serializer import dct_pkg::*; #(
    parameter int W         = sample_width(M_DEF, E_DEF),
    parameter int DCT_POINT = DCT_POINT_DEF
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   cap,
    input  logic [W*DCT_POINT-1:0] coef_in,
    dct_frame_sequencer_if.master  m,
    output logic                   done
);

    localparam int              IW       = idx_width(DCT_POINT);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DCT_POINT - 1);

    logic [W*DCT_POINT-1:0] coef_buf;
    logic [IW-1:0]          rd_idx;
    logic                   valid_q;
    logic                   m_fire;
    logic [W-1:0]           data_mux;

    assign m_fire  = valid_q && m.ready;
    assign done    = m_fire && (rd_idx == LAST_IDX);
    assign m.valid = valid_q;
    assign m.data  = data_mux;

    // Output is a pure function of registered rd_idx and buffer, so it is
    // automatically stable while the consumer stalls.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < DCT_POINT; i++) begin
            if (rd_idx == IW'(i)) begin
                data_mux = coef_buf[W*i +: W];
            end
        end
    end

    // Buffer contents are don't-care until the next capture, so no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            coef_buf <= coef_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= 1'b0;
            rd_idx  <= '0;
        end else if (cap) begin
            valid_q <= 1'b1;
            rd_idx  <= '0;
        end else if (m_fire) begin
            if (rd_idx == LAST_IDX) begin
                valid_q <= 1'b0;
                rd_idx  <= '0;
            end else begin
                rd_idx  <= rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dct_frame_sequencer.sv
// rtl/dct_frame_sequencer.sv - gathers a frame of samples, runs the parallel DCT core, streams coefficients
// Ports: clk, clr (sync active-high), s (sample stream slave), core_inp/core_en (to core),
//        core_outp/core_F (from core), m (coefficient stream master), busy, err (sticky timeout).
module dct_frame_sequencer import dct_pkg::*; #(
    parameter int M         = M_DEF,
    parameter int E         = E_DEF,
    parameter int DCT_POINT = DCT_POINT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    localparam int W        = sample_width(M, E)
) (
    input  logic                   clk,
    input  logic                   clr,
    dct_frame_sequencer_if.slave   s,
    output logic [W*DCT_POINT-1:0] core_inp,
    output logic                   core_en,
    input  logic [W*DCT_POINT-1:0] core_outp,
    input  logic                   core_F,
    dct_frame_sequencer_if.master  m,
    output logic                   busy,
    output logic                   err
);

    localparam int              IW       = idx_width(DCT_POINT);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DCT_POINT - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_t     state;
    seq_state_t     state_nxt;
    logic [IW-1:0]  wr_idx;
    logic [TW-1:0]  tmo_cnt;
    logic           s_fire;
    logic           cap;
    logic           tmo_hit;
    logic           drain_done;

    // ready is held low during clr so nothing is accepted on the reset edge
    assign s.ready = (state == S_LOAD) && !clr;
    assign s_fire  = s.valid && s.ready;

    // core_F only means something while the core is actually running
    assign cap     = (state == S_RUN) && core_F;
    assign tmo_hit = (state == S_RUN) && !core_F && (tmo_cnt == TMO_LAST);

    assign busy    = !clr && !((state == S_LOAD) && (wr_idx == '0));

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (s_fire && (wr_idx == LAST_IDX)) begin
                    state_nxt = S_GAP;
                end
            end
            // One idle cycle with core_en low lets the core clear its counters
            S_GAP: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_F) begin
                    state_nxt = S_DRAIN;
                end else if (tmo_hit) begin
                    state_nxt = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_LOAD;
            wr_idx   <= '0;
            tmo_cnt  <= '0;
            core_en  <= 1'b0;
            err      <= 1'b0;
            core_inp <= '0;
        end else begin
            state   <= state_nxt;
            // Registered so core_en is a clean decode of the RUN state
            core_en <= (state_nxt == S_RUN);

            if (s_fire) begin
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
                for (int i = 0; i < DCT_POINT; i++) begin
                    if (wr_idx == IW'(i)) begin
                        core_inp[W*i +: W] <= s.data;
                    end
                end
            end

            if (state == S_RUN) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

    dct_coef_serializer #(
        .W         (W),
        .DCT_POINT (DCT_POINT)
    ) u_serializer (
        .clk     (clk),
        .clr     (clr),
        .cap     (cap),
        .coef_in (core_outp),
        .m       (m),
        .done    (drain_done)
    );

endmodule

// File: tb/tb_dct_frame_sequencer.sv
// tb/tb_dct_frame_sequencer.sv - directed self-checking bench for dct_frame_sequencer
module tb_dct_frame_sequencer;

    localparam int N = 16;

    logic          clk;
    logic          clr;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic [32*N-1:0] core_inp;
    logic [32*N-1:0] core_outp;
    logic          core_en;
    logic          core_F;
    logic          busy;
    logic          err;

    logic          spur_f;
    logic          core_mode;
    logic          core_f_model;
    int            core_cnt;

    int            tests;
    int            fails;

    dct_frame_sequencer_if #(.W(32)) s_if ();
    dct_frame_sequencer_if #(.W(32)) m_if ();

    assign s_if.data   = s_data;
    assign s_if.valid  = s_valid;
    assign s_ready     = s_if.ready;
    assign m_data      = m_if.data;
    assign m_valid     = m_if.valid;
    assign m_if.ready  = m_ready;
    assign core_F      = core_f_model | spur_f;

    dct_frame_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .s         (s_if),
        .core_inp  (core_inp),
        .core_en   (core_en),
        .core_outp (core_outp),
        .core_F    (core_F),
        .m         (m_if),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done pulse in the 31st cycle of core_en high; coefficient k is
    // lane 15-k with the sign bit flipped.
    initial begin
        core_cnt     = 0;
        core_f_model = 1'b0;
        core_outp    = '0;
    end

    always @(negedge clk) begin
        if (core_en === 1'b1) core_cnt = core_cnt + 1;
        else                  core_cnt = 0;
        core_f_model = core_mode && (core_en === 1'b1) && (core_cnt == 31);
        if (core_f_model) begin
            for (int k = 0; k < N; k++) begin
                core_outp[32*k +: 32] = core_inp[32*(N-1-k) +: 32] ^ 32'h8000_0000;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full frame: load, gap, run, drain. stall uses m_ready pattern 1,0,0,1;
    // keep_valid leaves s_valid high after loading; abort_at stops the drain loop
    // at that drain cycle; spur_at pulses core_F during that load cycle.
    task automatic do_frame(input logic [31:0] base, input bit stall, input bit keep_valid,
                            input int abort_at, input int spur_at);
        logic [31:0] samp [N];
        logic [31:0] expc [N];
        logic [3:0]  pat;
        int n;
        int c;
        int k;
        pat = 4'b1001;
        for (int i = 0; i < N; i++) begin
            samp[i] = base + 32'(i) * 32'h0001_1000;
        end
        for (int i = 0; i < N; i++) begin
            expc[i] = samp[N-1-i] ^ 32'h8000_0000;
        end

        for (int i = 0; i < N; i++) begin
            chk("load_s_ready", 32'(s_ready), 32'd1);
            chk("load_m_valid", 32'(m_valid), 32'd0);
            s_valid = 1'b1;
            s_data  = samp[i];
            spur_f  = (i == spur_at);
            tick();
        end
        spur_f  = 1'b0;
        s_valid = keep_valid;
        s_data  = 32'hDEAD_BEEF;

        chk("gap_core_en", 32'(core_en), 32'd0);
        chk("gap_s_ready", 32'(s_ready), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        tick();

        chk("run_core_en", 32'(core_en), 32'd1);
        for (int i = 0; i < N; i++) begin
            chk("core_inp_lane", core_inp[32*i +: 32], samp[i]);
        end
        n = 0;
        while (core_en === 1'b1 && n < 200) begin
            chk("run_s_ready", 32'(s_ready), 32'd0);
            chk("run_m_valid", 32'(m_valid), 32'd0);
            n++;
            tick();
        end
        chk("run_len", 32'(n), 32'd31);

        c = 0;
        k = 0;
        while (k < N && c < 200 && c != abort_at) begin
            m_ready = stall ? pat[c % 4] : 1'b1;
            chk("drain_m_valid", 32'(m_valid), 32'd1);
            chk("drain_m_data", m_data, expc[k]);
            chk("drain_s_ready", 32'(s_ready), 32'd0);
            chk("drain_core_en", 32'(core_en), 32'd0);
            if (m_ready) k++;
            c++;
            tick();
        end
        m_ready = 1'b0;
        if (abort_at < 0) begin
            chk("drain_count", 32'(k), 32'd16);
            if (!stall) chk("drain_cycles", 32'(c), 32'd16);
            chk("post_m_valid", 32'(m_valid), 32'd0);
            chk("post_s_ready", 32'(s_ready), 32'd1);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        clr       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        spur_f    = 1'b0;
        core_mode = 1'b1;
        repeat (3) tick();

        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_inp", 32'(|core_inp), 32'd0);
        clr = 1'b0;
        #1;
        chk("first_s_ready", 32'(s_ready), 32'd1);

        // Basic frame
        do_frame(32'h3F80_0000, 1'b0, 1'b0, -1, -1);

        // Core never finishes
        core_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h3C00_0000 + 32'(i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        chk("tmo_core_en_rise", 32'(core_en), 32'd1);
        repeat (63) tick();
        chk("tmo_core_en_hold", 32'(core_en), 32'd1);
        chk("tmo_err_pre", 32'(err), 32'd0);
        tick();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_core_en_off", 32'(core_en), 32'd0);
        chk("tmo_s_ready", 32'(s_ready), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        core_mode = 1'b1;

        // Spurious core_F while idle in LOAD
        spur_f = 1'b1;
        tick();
        spur_f = 1'b0;
        chk("spur_idle_m_valid", 32'(m_valid), 32'd0);
        chk("spur_idle_core_en", 32'(core_en), 32'd0);
        chk("spur_idle_s_ready", 32'(s_ready), 32'd1);
        chk("spur_idle_busy", 32'(busy), 32'd0);

        // Spurious core_F mid-load plus stalled drain
        do_frame(32'h4000_0000, 1'b1, 1'b0, -1, 7);
        chk("err_sticky", 32'(err), 32'd1);

        // clr at the 5th drain cycle
        do_frame(32'h4100_0000, 1'b0, 1'b0, 4, -1);
        clr = 1'b1;
        tick();
        chk("clr_m_valid", 32'(m_valid), 32'd0);
        chk("clr_core_en", 32'(core_en), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_s_ready", 32'(s_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        clr = 1'b0;
        #1;
        chk("clr_release_s_ready", 32'(s_ready), 32'd1);

        // Back-to-back frames with s_valid held high
        do_frame(32'h4200_0000, 1'b0, 1'b1, -1, -1);
        do_frame(32'h4300_0000, 1'b0, 1'b1, -1, -1);
        s_valid = 1'b0;
        chk("final_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dct_frame_sequencer.md
DCT_FRAME_SEQUENCER -- requirements
Module: dct_frame_sequencer

Interface
REQ-001 Parameter M, default 23, mantissa width of IEEE-754 sample.
REQ-002 Parameter E, default 8, exponent width; sample width W = M+E+1.
REQ-003 Parameter DCT_POINT, default 16, samples per frame.
REQ-004 Parameter TIMEOUT, default 64, max cycles from core_en rise to core_F.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 clr  input  1  reset, synchronous, active-high.
REQ-007 s_data  input  W  time-domain sample.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  sequencer accepts sample this cycle.
REQ-010 core_inp  output  W*DCT_POINT  parallel frame to DCT core; lane i at bits [W*i +: W].
REQ-011 core_en  output  1  DCT core enable, held high for the whole computation.
REQ-012 core_outp  input  W*DCT_POINT  parallel coefficients from core; coefficient k at [W*k +: W].
REQ-013 core_F  input  1  one-cycle core done pulse.
REQ-014 m_data  output  W  coefficient out.
REQ-015 m_valid  output  1  m_data valid.
REQ-016 m_ready  input  1  downstream accepts m_data.
REQ-017 busy  output  1  high in any state except LOAD with zero samples held.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 FSM states LOAD, GAP, RUN, DRAIN; encoding 2-bit.
REQ-020 LOAD: s_ready=1; each s_valid&&s_ready writes s_data to lane wr_idx, wr_idx increments from 0.
REQ-021 Accept with wr_idx=DCT_POINT-1: wr_idx wraps to 0, go to GAP.
REQ-022 GAP: lasts exactly one cycle with core_en=0, guaranteeing core counters cleared, then RUN.
REQ-023 RUN: core_en=1, core_inp stable, s_ready=0; timeout counter increments each cycle.
REQ-024 core_F=1 in RUN: capture core_outp into output buffer same edge, core_en=0 next cycle, go DRAIN, rd_idx=0.
REQ-025 Timeout counter reaching TIMEOUT-1 without core_F: err<=1, core_en<=0, frame discarded, go LOAD.
REQ-026 core_F outside RUN is ignored.
REQ-027 DRAIN: m_valid=1, m_data = buffer lane rd_idx; rd_idx increments on m_valid&&m_ready.
REQ-028 m_data/m_valid hold unchanged while m_valid&&!m_ready.
REQ-029 Handshake at rd_idx=DCT_POINT-1: m_valid=0 next cycle, go LOAD.
REQ-030 s_ready and m_valid never both high.
REQ-031 Throughput: one sample per cycle in LOAD, one coefficient per cycle in DRAIN with m_ready held high.
REQ-032 No arithmetic on data; samples and coefficients passed bit-exact.
REQ-033 err cleared only by clr.

Reset
REQ-034 clr high at any edge, including mid-RUN or mid-DRAIN: state LOAD, wr_idx=0, rd_idx=0, timeout counter 0, core_en=0, s_ready=0 during clr, m_valid=0, err=0, busy=0, core_inp=0.
REQ-035 First cycle after clr deasserts: s_ready=1.
REQ-036 Captured buffer contents need not be reset.

Structure
REQ-037 Shared package dct_pkg holds W derivation, DCT_POINT default, FSM state constants, index width clog2(DCT_POINT).
REQ-038 One natural sub-module: dct_coef_serializer (buffer, rd_idx, m_* handshake), instantiated once.

Verification
REQ-039 Load samples 0x3F800000..(16 distinct), core model asserts core_F 30 cycles after core_en -> core_inp lanes match order, m_data emits model coefficients k=0..15 in order, core_en high exactly 30 cycles plus one.
REQ-040 Core model never asserts core_F -> err=1 at cycle TIMEOUT after core_en rise, core_en=0, s_ready=1 next cycle.
REQ-041 m_ready toggles 1,0,0,1 pattern during DRAIN -> no coefficient dropped or duplicated, m_data stable while stalled.
REQ-042 clr pulsed at 5th DRAIN cycle -> m_valid=0, core_en=0, err=0 next cycle; next frame processed correctly.
REQ-043 Back-to-back frames with s_valid high continuously -> core_en low exactly one cycle (GAP) before each RUN; s_ready=0 throughout RUN/DRAIN.
REQ-044 Spurious core_F during LOAD -> ignored, no state change, no m_valid.
